accel_mem_request_issuer: RTL

Serialises accelerator memory requests into the 128-bit packed command format consumed by the accelerator-to-memory bridge.
- Buffers requests in a small FIFO.
- Holds each Avalon-MM read/write until the bridge drops waitrequest.
- Returns size-masked read data to the accelerator over a valid/ready response port.

Sits between the accelerator datapath and the bridge's accel-side slave port.

---
 rtl/accel_mem_pkg.sv | 67 ++++++
 rtl/accel_req_fifo.sv | 64 ++++++
 rtl/accel_mem_request_issuer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/accel_mem_pkg.sv
// Shared types, field positions and helpers for the accelerator memory request issuer.
package accel_mem_pkg;

  localparam int ADDR_W = 31;
  localparam int DATA_W = 64;
  localparam int CMD_W  = 128;

  localparam logic [1:0] SIZE_8  = 2'd0;
  localparam logic [1:0] SIZE_16 = 2'd1;
  localparam logic [1:0] SIZE_32 = 2'd2;
  localparam logic [1:0] SIZE_64 = 2'd3;

  localparam int ADDR_LSB = 0;
  localparam int DATA_LSB = 32;
  localparam int FLAG8    = 96;
  localparam int FLAG16   = 97;
  localparam int FLAG64   = 98;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        size;
  } mem_req_t;

  // Only the low three address bits matter for any supported access size.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    logic mis;
    unique case (size)
      SIZE_16: mis = addr_lo[0];
      SIZE_32: mis = |addr_lo[1:0];
      SIZE_64: mis = |addr_lo[2:0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // 32-bit accesses are encoded by all three size flags being clear.
  function automatic logic [CMD_W-1:0] pack_cmd(input mem_req_t r);
    logic [CMD_W-1:0] cmd;
    cmd = '0;
    cmd[ADDR_LSB +: ADDR_W] = r.addr;
    if (r.write) cmd[DATA_LSB +: DATA_W] = r.wdata;
    cmd[FLAG8]  = (r.size == SIZE_8);
    cmd[FLAG16] = (r.size == SIZE_16);
    cmd[FLAG64] = (r.size == SIZE_64);
    return cmd;
  endfunction

  function automatic logic [DATA_W-1:0] mask_rdata(input logic [DATA_W-1:0] d, input logic [1:0] size);
    logic [DATA_W-1:0] m;
    unique case (size)
      SIZE_8:  m = {56'b0, d[7:0]};
      SIZE_16: m = {48'b0, d[15:0]};
      SIZE_32: m = {32'b0, d[31:0]};
      default: m = d;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/accel_req_fifo.sv
// Request FIFO with registered full/empty flags and single-cycle push/pop.
module accel_req_fifo
  import accel_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push_i,
  input  mem_req_t push_data_i,
  input  logic     pop_i,
  output mem_req_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  mem_req_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  // NOTE: count_d gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
    end
  end

  // NOTE: the storage array is not reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/accel_mem_request_issuer.sv
// Serialises buffered accelerator requests into packed bridge commands and returns read data.
module accel_mem_request_issuer
  import accel_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [30:0]  req_addr,
  input  logic [63:0]  req_wdata,
  input  logic [1:0]   req_size,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [63:0]  rsp_rdata,
  output logic         rsp_err,
  output logic         err_misaligned,
  output logic [127:0] writedata_to_bridge,
  output logic         address_to_bridge,
  output logic         write_to_bridge,
  output logic         read_to_bridge,
  input  logic [127:0] readdata_from_bridge,
  input  logic         waitrequest_from_bridge
);

  state_e       state_q;
  logic [127:0] cmd_q;
  logic         write_q, read_q;
  logic [1:0]   size_q;
  logic         rsp_valid_q, rsp_err_q, err_q;
  logic [63:0]  rsp_rdata_q;

  mem_req_t req_in, head;
  logic     fifo_full, fifo_empty, pop;
  logic     head_mis, head_ok;
  logic     unused_rdata_hi;

  assign req_in = '{write: req_write, addr: req_addr, wdata: req_wdata, size: req_size};

  accel_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (req_valid),
    .push_data_i (req_in),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign head_mis = is_misaligned(head.addr[2:0], head.size);
  assign head_ok  = !fifo_empty && !head_mis;

  // Misaligned heads are popped from IDLE only; BUS and RSP chain directly into aligned heads.
  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      ST_IDLE: pop = !fifo_empty;
      ST_BUS:  pop = !waitrequest_from_bridge && write_q && head_ok && head.write;
      ST_RSP:  pop = rsp_ready && head_ok;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      size_q      <= SIZE_8;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (head_mis) begin
              err_q <= 1'b1;
              if (!head.write) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
                rsp_rdata_q <= '0;
                state_q     <= ST_RSP;
              end
            end else begin
              cmd_q   <= pack_cmd(head);
              write_q <= head.write;
              read_q  <= !head.write;
              size_q  <= head.size;
              state_q <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          if (!waitrequest_from_bridge) begin
            if (write_q) begin
              if (pop) begin
                cmd_q  <= pack_cmd(head);
                size_q <= head.size;
              end else begin
                write_q <= 1'b0;
                state_q <= ST_IDLE;
              end
            end else begin
              read_q      <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= mask_rdata(readdata_from_bridge[63:0], size_q);
              state_q     <= ST_RSP;
            end
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            if (head_ok) begin
              cmd_q   <= pack_cmd(head);
              write_q <= head.write;
              read_q  <= !head.write;
              size_q  <= head.size;
              state_q <= ST_BUS;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The bridge already right-aligns read data, so only the low 64 bits carry information.
  assign unused_rdata_hi = ^readdata_from_bridge[127:64];

  assign req_ready           = !fifo_full;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_rdata           = rsp_rdata_q;
  assign rsp_err             = rsp_err_q;
  assign err_misaligned      = err_q;
  assign writedata_to_bridge = cmd_q;
  assign address_to_bridge   = 1'b0;
  assign write_to_bridge     = write_q;
  assign read_to_bridge      = read_q;

endmodule
